// File: rtl/srt_div_pkg.sv
// Shared types and helpers for the SRT stream divider: FSM states, quotient digit
// encoding and the signed-overflow predicate.
package srt_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ITER,
        ST_FIX,
        ST_OUT
    } state_t;

    // Quotient digit in {-1, 0, +1}, held as a two-bit two's complement value.
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    function automatic logic sdiv_overflow(
        input logic is_signed,
        input logic x_is_min,
        input logic y_is_neg_one
    );
        return is_signed & x_is_min & y_is_neg_one;
    endfunction

endpackage

// File: rtl/srt_div_lzc.sv
// Combinational leading-zero counter; an all-zero input reports N.
module srt_div_lzc #(
    parameter int N = 32
) (
    input  logic [N-1:0]           i_data,
    output logic [$clog2(N+1)-1:0] o_count
);
    localparam int CNT_W = $clog2(N + 1);

    always_comb begin
        o_count = CNT_W'(N);
        for (int i = 0; i < N; i++) begin
            if (i_data[i]) o_count = CNT_W'(N - 1 - i);
        end
    end

endmodule

// File: rtl/srt_div_stream.sv
// Handshaked radix-2 SRT divider: carry-save residual, on-the-fly quotient conversion.
// Define SRT_DIV_EARLY_TERM_EN to skip leading quotient bits implied by operand magnitudes.
module srt_div_stream
    import srt_div_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_q,
    output logic [N-1:0]     out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_by_zero,
    output logic             out_overflow
);
    // Residual frame: value 1.0 sits at bit 2N, with sign and two integer bits above it.
    localparam int W    = 2 * N + 3;
    localparam int LZ_W = $clog2(N + 1);
    localparam int SH_W = LZ_W + 1;

    state_t r_state, w_state_next;

    logic [N-1:0]     r_x_abs, r_y_abs;
    logic             r_neg_q, r_neg_r;
    logic [W-1:0]     r_d, r_ws, r_wc;
    logic [N-1:0]     r_q, r_qn;
    logic [LZ_W-1:0]  r_cnt;
    logic [SH_W-1:0]  r_rshift;
    logic [N-1:0]     r_out_q, r_out_r;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_dbz, r_ovf;

    logic             w_fire_in, w_fire_out, w_y_zero, w_ovf;
    logic [LZ_W-1:0]  w_lzy, w_k;
    logic [SH_W-1:0]  w_pre_shift;

    assign in_ready        = (r_state == ST_IDLE) && rst;
    assign out_valid       = (r_state == ST_OUT);
    assign w_fire_in       = in_valid && in_ready;
    assign w_fire_out      = out_valid && out_ready;
    assign w_y_zero        = (in_y == '0);
    assign w_ovf           = sdiv_overflow(in_signed, in_x == {1'b1, {(N-1){1'b0}}}, &in_y);
    assign out_q           = r_out_q;
    assign out_r           = r_out_r;
    assign out_tag         = r_out_tag;
    assign out_div_by_zero = r_dbz;
    assign out_overflow    = r_ovf;

    srt_div_lzc #(.N(N)) u_lzc_y (.i_data(r_y_abs), .o_count(w_lzy));

`ifdef SRT_DIV_EARLY_TERM_EN
    logic [LZ_W-1:0] w_lzx;

    srt_div_lzc #(.N(N)) u_lzc_x (.i_data(r_x_abs), .o_count(w_lzx));

    // Quotient has at most lzy - lzx + 1 significant bits; fewer means x < y.
    always_comb begin
        w_k = '0;
        if (w_lzy >= w_lzx) w_k = LZ_W'(w_lzy - w_lzx) + LZ_W'(1);
    end
    assign w_pre_shift = SH_W'(w_lzy) + SH_W'(N) - SH_W'(w_k);
`else
    assign w_k         = LZ_W'(N);
    assign w_pre_shift = SH_W'(w_lzy);
`endif

    // One SRT step: 4-bit estimate of 2w from both carry-save words selects the digit.
    logic [W-1:0] w_ws2, w_wc2, w_addend, w_sum, w_carry;
    logic [W-2:0] w_maj;
    logic [3:0]   w_est;
    logic [1:0]   w_digit;

    always_comb begin
        w_ws2 = r_ws << 1;
        w_wc2 = r_wc << 1;
        w_est = w_ws2[W-1 -: 4] + w_wc2[W-1 -: 4];
        if (!w_est[3])              w_digit = DIG_POS;
        else if (w_est == 4'b1111)  w_digit = DIG_ZERO;
        else                        w_digit = DIG_NEG;
        case (w_digit)
            DIG_POS: w_addend = ~r_d;
            DIG_NEG: w_addend = r_d;
            default: w_addend = '0;
        endcase
        w_sum   = w_ws2 ^ w_wc2 ^ w_addend;
        w_maj   = (w_ws2[W-2:0] & w_wc2[W-2:0]) | (w_ws2[W-2:0] & w_addend[W-2:0])
                | (w_wc2[W-2:0] & w_addend[W-2:0]);
        w_carry = {w_maj, w_digit == DIG_POS};
    end

    logic [W-1:0] w_rsum, w_rfix;
    logic [N-1:0] w_qmag, w_rmag;

    always_comb begin
        w_rsum = r_ws + r_wc;
        w_rfix = w_rsum + (w_rsum[W-1] ? r_d : '0);
        w_qmag = w_rsum[W-1] ? r_qn : r_q;
        w_rmag = N'(w_rfix >> r_rshift);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_fire_in) w_state_next = (w_y_zero || w_ovf) ? ST_OUT : ST_NORM;
            ST_NORM: w_state_next = (w_k == '0) ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == LZ_W'(1)) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_OUT;
            ST_OUT:  if (w_fire_out) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_q   <= '0;
            r_out_r   <= '0;
            r_out_tag <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_fire_in) begin
            r_out_tag <= in_tag;
            r_dbz     <= w_y_zero;
            r_ovf     <= w_ovf;
            if (w_y_zero) begin
                r_out_q <= '1;
                r_out_r <= in_x;
            end else if (w_ovf) begin
                r_out_q <= {1'b1, {(N-1){1'b0}}};
                r_out_r <= '0;
            end
        end else if (r_state == ST_FIX) begin
            r_out_q <= r_neg_q ? -w_qmag : w_qmag;
            r_out_r <= r_neg_r ? -w_rmag : w_rmag;
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            ST_IDLE: if (w_fire_in) begin
                r_x_abs <= (in_signed && in_x[N-1]) ? -in_x : in_x;
                r_y_abs <= (in_signed && in_y[N-1]) ? -in_y : in_y;
                r_neg_q <= in_signed && (in_x[N-1] ^ in_y[N-1]);
                r_neg_r <= in_signed && in_x[N-1];
            end
            ST_NORM: begin
                r_d      <= W'(r_y_abs) << (SH_W'(w_lzy) + SH_W'(N));
                r_ws     <= W'(r_x_abs) << w_pre_shift;
                r_wc     <= '0;
                r_q      <= '0;
                r_qn     <= '1;
                r_cnt    <= w_k;
                r_rshift <= SH_W'(w_lzy) + SH_W'(N);
            end
            ST_ITER: begin
                r_ws  <= w_sum;
                r_wc  <= w_carry;
                r_cnt <= r_cnt - LZ_W'(1);
                case (w_digit)
                    DIG_POS: begin
                        r_q  <= {r_q[N-2:0], 1'b1};
                        r_qn <= {r_q[N-2:0], 1'b0};
                    end
                    DIG_NEG: begin
                        r_q  <= {r_qn[N-2:0], 1'b1};
                        r_qn <= {r_qn[N-2:0], 1'b0};
                    end
                    default: begin
                        r_q  <= {r_q[N-2:0], 1'b0};
                        r_qn <= {r_qn[N-2:0], 1'b1};
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_srt_div_stream.sv
// Bench for srt_div_stream: directed cases, backpressure, mid-division reset and random
// operands, all compared against an arithmetic reference model.
module tb_srt_div_stream;
    localparam int N     = 32;
    localparam int TAG_W = 4;
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_signed = 1'b0;
    logic [N-1:0]     in_x = '0;
    logic [N-1:0]     in_y = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_q, out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_div_by_zero, out_overflow;

    always #5 clk = ~clk;

    srt_div_stream #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_tag(out_tag),
        .out_div_by_zero(out_div_by_zero), .out_overflow(out_overflow)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;

    logic [N-1:0]     exp_q, exp_r;
    logic [TAG_W-1:0] exp_tag;
    logic             exp_dbz, exp_ovf;
    int               exp_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bitlen(input logic [N-1:0] v);
        int b = 0;
        for (int i = 0; i < N; i++) if (v[i]) b = i + 1;
        return b;
    endfunction

    function automatic logic [N-1:0] mag(input logic sgn, input logic [N-1:0] v);
        return (sgn && v[N-1]) ? -v : v;
    endfunction

    // Expected results follow C semantics on 64-bit arithmetic plus the defined special cases.
    task automatic model(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y);
        longint         xs, ys, qs, rs;
        logic [2*N-1:0] xu, yu, qu, ru;
        int             k;
        exp_dbz = 1'b0;
        exp_ovf = 1'b0;
        exp_lat = N + 3;
        if (y == '0) begin
            exp_q   = '1;
            exp_r   = x;
            exp_dbz = 1'b1;
            exp_lat = 1;
        end else if (sgn && x == MIN_V && y == '1) begin
            exp_q   = MIN_V;
            exp_r   = '0;
            exp_ovf = 1'b1;
            exp_lat = 1;
        end else begin
            if (sgn) begin
                xs = longint'($signed(x));
                ys = longint'($signed(y));
                qs = xs / ys;
                rs = xs % ys;
                exp_q = qs[N-1:0];
                exp_r = rs[N-1:0];
            end else begin
                xu = (2*N)'(x);
                yu = (2*N)'(y);
                qu = xu / yu;
                ru = xu % yu;
                exp_q = qu[N-1:0];
                exp_r = ru[N-1:0];
            end
`ifdef SRT_DIV_EARLY_TERM_EN
            k = bitlen(mag(sgn, x)) - bitlen(mag(sgn, y)) + 1;
            if (k < 0) k = 0;
            if (k > N) k = N;
            exp_lat = k + 3;
`else
            k = N;
`endif
        end
    endtask

    task automatic start_req(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic [TAG_W-1:0] tag);
        int waited = 0;
        in_signed = sgn;
        in_x      = x;
        in_y      = y;
        in_tag    = tag;
        in_valid  = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        model(sgn, x, y);
        exp_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y);
        int lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_valid", 64'(out_valid), 64'd1);
        check("quotient", 64'(out_q), 64'(exp_q));
        check("remainder", 64'(out_r), 64'(exp_r));
        check("tag", 64'(out_tag), 64'(exp_tag));
        check("div_by_zero", 64'(out_div_by_zero), 64'(exp_dbz));
        check("overflow", 64'(out_overflow), 64'(exp_ovf));
        n_txn++;
        $display("txn %0d: signed=%0b x=%h y=%h tag=%0d -> q=%h r=%h dbz=%0b ovf=%0b lat=%0d",
                 n_txn, sgn, x, y, exp_tag, out_q, out_r, out_div_by_zero, out_overflow, lat);
    endtask

    task automatic finish_txn();
        @(posedge clk);
        #1;
        check("valid_after_xfer", 64'(out_valid), 64'd0);
        check("ready_after_xfer", 64'(in_ready), 64'd1);
    endtask

    task automatic do_div(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [TAG_W-1:0] tag);
        start_req(sgn, x, y, tag);
        wait_result(sgn, x, y);
        finish_txn();
    endtask

    initial begin
        logic         s;
        logic [N-1:0] rx, ry;
        logic [N-1:0] held_q, held_r;
        int           sel;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_q", 64'(out_q), 64'd0);
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_flags", 64'({out_div_by_zero, out_overflow}), 64'd0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed cases
        do_div(1'b0, 32'd100, 32'd7, 4'd3);
        do_div(1'b1, -32'sd7, 32'sd2, 4'd1);
        do_div(1'b1, 32'sd7, -32'sd2, 4'd2);
        do_div(1'b0, 32'h0000_1234, 32'h0, 4'd4);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6);
        do_div(1'b1, 32'h8000_0000, 32'h0000_0001, 4'd7);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd8);
        do_div(1'b0, 32'd5, 32'd9, 4'd9);
        do_div(1'b0, 32'd0, 32'd3, 4'd10);

        // Backpressure: result held while a second request waits
        out_ready = 1'b0;
        start_req(1'b0, 32'd1000, 32'd13, 4'd11);
        wait_result(1'b0, 32'd1000, 32'd13);
        held_q    = exp_q;
        held_r    = exp_r;
        in_signed = 1'b0;
        in_x      = 32'hDEAD_BEEF;
        in_y      = 32'h0000_1234;
        in_tag    = 4'd12;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_q", 64'(out_q), 64'(held_q));
            check("hold_r", 64'(out_r), 64'(held_r));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_after_xfer", 64'(out_valid), 64'd0);
        check("bp_ready_after_xfer", 64'(in_ready), 64'd1);
        do_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 4'd12);

        // Reset in the middle of an iteration
        start_req(1'b0, 32'h0000_FFFF, 32'd3, 4'd13);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_ready_release", 64'(in_ready), 64'd1);
        do_div(1'b0, 32'd9, 32'd3, 4'd14);

        // Random operands with assorted magnitudes and occasional special cases
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            rx  = $urandom >> $urandom_range(0, 31);
            ry  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rx = -rx;
            if ($urandom_range(0, 1) == 1) ry = -ry;
            sel = $urandom_range(0, 15);
            if (sel == 0) ry = '0;
            if (sel == 1) begin
                rx = MIN_V;
                ry = '1;
            end
            if (sel == 2) ry = 32'd1;
            do_div(s, rx, ry, TAG_W'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/srt_div_stream.md
# srt_div_stream

Parametrised, handshaked radix-2 SRT integer divider, next generation of the team's iterative divider. Accepts signed or unsigned operand pairs over a valid/ready stream, produces quotient/remainder with C-style signed semantics, defined divide-by-zero and overflow results, and a pass-through tag. Sits beside the ALU as a multi-cycle execution unit; one division in flight at a time.

## Interface
- N, 32: operand width (≥ 4, power of two not required)
- TAG_W, 4: width of request tag carried to the result
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- in_signed  in  1  operands are two's complement
- in_x  in  N  dividend
- in_y  in  N  divisor
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_q  out  N  quotient
- out_r  out  N  remainder
- out_tag  out  TAG_W  tag of the request
- out_div_by_zero  out  1  in_y was zero
- out_overflow  out  1  signed MIN / -1

## Operation
- Reset (rst=0 at an edge): state IDLE, in_ready=0 during reset cycle then 1, out_valid=0, out_q/out_r/out_tag=0, flags=0. Any in-flight division discarded.
- States: IDLE -> NORM -> ITER -> FIX -> OUT -> IDLE; IDLE -> OUT directly for special cases.
- IDLE: in_ready=1. Transfer on in_valid&in_ready: latch operands, sign mode, tag; absolute values formed (signed mode only).
- Special cases decided in IDLE at acceptance: y=0 -> q=all ones, r=x, div_by_zero=1. Signed x=MIN, y=-1 -> q=MIN, r=0, overflow=1. Both go to OUT.
- NORM: leading-zero count of |y| (lzy); divisor left-shifted by lzy; dividend placed in partial remainder; iteration count k set (see Configuration).
- ITER: one quotient digit per cycle from {-1,0,+1} using top 4 bits of carry-save partial remainder (≥0 -> +1, -1/2 ≤ pr < 0 -> 0, else -1); quotient kept as Q/QN on-the-fly registers, no final subtraction of digit vectors.
- FIX: resolve carry-save remainder; if negative add normalised divisor and decrement quotient; shift remainder right by lzy. Apply signs: q negated if x,y signs differ; r takes sign of x (signed mode). Truncation toward zero.
- OUT: out_valid=1, outputs stable until out_valid&out_ready; then IDLE. in_ready=0 in all states except IDLE.
- Unsigned mode: in_signed=0 treats MSB as magnitude; no overflow flag.

## Timing
- Acceptance edge T. Normal path: NORM cycle T+1, ITER k cycles, FIX one cycle, out_valid rises at T+k+3 (k=N without early termination -> latency N+3).
- Special cases: out_valid at T+1.
- Back-to-back: next request accepted no earlier than the cycle after output transfer (in_ready rises the cycle following out_valid&out_ready).
- out_ready held low: result held indefinitely, no state change.
- in_valid dropped before acceptance: no effect; inputs sampled only on transfer edge.

## Configuration
- SRT_DIV_EARLY_TERM_EN defined: NORM also counts lzx of |x|; k = lzy − lzx + 1 clipped to [0, N]; dividend pre-shifted so leading quotient bits are skipped; k=0 gives q=0, r=x with out_valid at T+3.
- Undefined: k = N always; latency fixed at N+3 for non-special operands.
- Results identical in both builds; only latency differs.

## Structure
- Package srt_div_pkg: state enum (IDLE, NORM, ITER, FIX, OUT), digit encoding constants, function for signed-overflow detection.
- Sub-module srt_div_lzc: parametrised combinational leading-zero counter, instantiated once (twice with SRT_DIV_EARLY_TERM_EN).
- Carry-save add/sub of partial remainder and on-the-fly quotient conversion stay inline.

## Test plan
- N=32 unsigned 100 / 7, tag 3 -> q=14, r=2, tag 3, flags 0; out_valid at T+35 (no early term).
- Signed −7 / 2 -> q=−3, r=−1; signed 7 / −2 -> q=−3, r=1.
- y=0, x=0x1234 -> q=0xFFFFFFFF, r=0x1234, div_by_zero=1, out_valid at T+1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, overflow=1.
- out_ready low 10 cycles with in_valid high -> outputs stable, in_ready=0, second request accepted after transfer.
- rst low during ITER -> out_valid=0 next cycle, in_ready=1 after release, next 9/3 -> q=3, r=0.
